// File: rtl/td4_cpu_top.sv
// TD4-class 4-bit teaching CPU: ROM, A/B, LED port, PC, carry, 4-bit adder.
// Optional TD4_INPUT_SYNC_EN adds a 2-flop synchronizer on pin_switch.
module td4_cpu_top #(
  parameter int unsigned  CLK_DIV   = 1,
  parameter logic [127:0] ROM_IMAGE =
    128'h0000_0000_0000_0000_00F6_BFE2_5190_4020
) (
  input  logic       pin_clock,
  input  logic       pin_n_reset,
  input  logic [3:0] pin_switch,
  output logic [3:0] pin_led
);

  localparam logic [23:0] CNT_MAX = 24'(CLK_DIV - 1);

  logic [23:0] div_cnt;
  logic        step;

  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] led;
  logic [3:0] pc;
  logic       carry;

  logic [7:0] instr;
  logic [3:0] op;
  logic [3:0] im;
  logic [3:0] sw_in;

  logic [3:0] src;
  logic [3:0] sum;
  logic       c;
  logic       wr_a;
  logic       wr_b;
  logic       wr_led;
  logic       use_c;
  logic       jmp;

  assign step = (div_cnt == CNT_MAX);

  always_ff @(posedge pin_clock or negedge pin_n_reset) begin
    if (!pin_n_reset) begin
      div_cnt <= '0;
    end else if (step) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 24'd1;
    end
  end

`ifdef TD4_INPUT_SYNC_EN
  logic [3:0] sw_meta;
  logic [3:0] sw_sync;

  always_ff @(posedge pin_clock or negedge pin_n_reset) begin
    if (!pin_n_reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= pin_switch;
      sw_sync <= sw_meta;
    end
  end

  assign sw_in = sw_sync;
`else
  assign sw_in = pin_switch;
`endif

  assign instr = ROM_IMAGE[{pc, 3'b000} +: 8];
  assign op    = instr[7:4];
  assign im    = instr[3:0];

  always_comb begin
    src    = 4'h0;
    wr_a   = 1'b0;
    wr_b   = 1'b0;
    wr_led = 1'b0;
    use_c  = 1'b0;
    jmp    = 1'b0;
    unique case (op)
      4'h0: begin src = a;     wr_a = 1'b1;   use_c = 1'b1; end
      4'h1: begin src = b;     wr_a = 1'b1;   use_c = 1'b1; end
      4'h2: begin src = sw_in; wr_a = 1'b1;   use_c = 1'b1; end
      4'h3: begin src = 4'h0;  wr_a = 1'b1;   use_c = 1'b1; end
      4'h4: begin src = a;     wr_b = 1'b1;   use_c = 1'b1; end
      4'h5: begin src = b;     wr_b = 1'b1;   use_c = 1'b1; end
      4'h6: begin src = sw_in; wr_b = 1'b1;   use_c = 1'b1; end
      4'h7: begin src = 4'h0;  wr_b = 1'b1;   use_c = 1'b1; end
      4'h9: begin src = b;     wr_led = 1'b1; use_c = 1'b1; end
      4'hB: begin src = 4'h0;  wr_led = 1'b1; end
      4'hE: jmp = ~carry;
      4'hF: jmp = 1'b1;
      default: ;
    endcase
  end

  assign {c, sum} = {1'b0, src} + {1'b0, im};

  always_ff @(posedge pin_clock or negedge pin_n_reset) begin
    if (!pin_n_reset) begin
      a     <= '0;
      b     <= '0;
      led   <= '0;
      pc    <= '0;
      carry <= 1'b0;
    end else if (step) begin
      if (wr_a)   a   <= sum;
      if (wr_b)   b   <= sum;
      if (wr_led) led <= sum;
      pc    <= jmp ? im : pc + 4'd1;
      carry <= use_c & c;
    end
  end

  assign pin_led = led;

endmodule

// File: tb/tb_td4_cpu_top.sv
// Bench for td4_cpu_top: default program, prescaled run, custom ROM,
// random switch values, all checked against an arithmetic model.
module tb_td4_cpu_top;

  localparam logic [127:0] COV_IMG =
    128'hC4B7_A09C_5F72_6345_2180_BAE6_10E5_033E;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw = 4'h0;
  logic [3:0] led1;
  logic [3:0] led2;
  logic [3:0] led3;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] rom_m [2][16];
  int m_a, m_b, m_led, m_pc, m_c;

  always #5 clk = ~clk;

  td4_cpu_top dut1 (
    .pin_clock   (clk),
    .pin_n_reset (rst_n),
    .pin_switch  (sw),
    .pin_led     (led1)
  );

  td4_cpu_top #(.CLK_DIV(4)) dut2 (
    .pin_clock   (clk),
    .pin_n_reset (rst_n),
    .pin_switch  (sw),
    .pin_led     (led2)
  );

  td4_cpu_top #(.ROM_IMAGE(COV_IMG)) dut3 (
    .pin_clock   (clk),
    .pin_n_reset (rst_n),
    .pin_switch  (sw),
    .pin_led     (led3)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_a = 0; m_b = 0; m_led = 0; m_pc = 0; m_c = 0;
  endtask

  task automatic model_step(input int r, input int s);
    int op, im, res, npc, nc;
    op  = int'(rom_m[r][m_pc]) / 16;
    im  = int'(rom_m[r][m_pc]) % 16;
    npc = (m_pc + 1) % 16;
    res = 0;
    nc  = 0;
    case (op)
      0: res = m_a + im;
      1: res = m_b + im;
      2: res = s + im;
      3: res = im;
      4: res = m_a + im;
      5: res = m_b + im;
      6: res = s + im;
      7: res = im;
      9: res = m_b + im;
      11: m_led = im;
      14: if (m_c == 0) npc = im;
      15: npc = im;
      default: ;
    endcase
    if (op <= 7 || op == 9) nc = res / 16;
    if (op <= 3) m_a = res % 16;
    else if (op <= 7) m_b = res % 16;
    else if (op == 9) m_led = res % 16;
    m_c  = nc;
    m_pc = npc;
  endtask

  task automatic cmp_dut1(input string tag);
    check({tag, ".led"},   led1,       m_led);
    check({tag, ".pc"},    dut1.pc,    m_pc);
    check({tag, ".a"},     dut1.a,     m_a);
    check({tag, ".b"},     dut1.b,     m_b);
    check({tag, ".carry"}, dut1.carry, m_c);
  endtask

  task automatic run_default(input int s, input int nsteps);
    rst_n = 1'b0;
    sw = 4'(s);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    for (int i = 1; i <= nsteps; i++) begin
      @(negedge clk);
      model_step(0, s);
      cmp_dut1("def");
      if (s == 6 && i == 3) check("sw6_led_step3", led1, 6);
      if (s == 6 && i == 6) check("sw6_led_step6", led1, 7);
      if (s == 15 && i == 3) check("swf_led_step3", led1, 15);
      if (s == 15 && i == 4) check("swf_carry", dut1.carry, 1);
      if (s == 15 && i == 7) check("swf_pc_step7", dut1.pc, 6);
    end
  endtask

  initial begin
    logic [127:0] img;
    int s, pa, pb, pl;

    rom_m[0] = '{8'h20, 8'h40, 8'h90, 8'h51, 8'hE2, 8'hBF, 8'hF6, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    img = COV_IMG;
    for (int i = 0; i < 16; i++) rom_m[1][i] = img[i*8 +: 8];

    // reset state
    rst_n = 1'b0;
    sw = 4'h6;
    #10;
    model_reset();
    cmp_dut1("rst");

    // default program, switches = 6, runs into the halt loop
    run_default(6, 45);
    check("halt_led", led1, 15);
    check("halt_pc", dut1.pc, 6);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      check("hold_led", led1, 15);
    end
    check("hold_pc", dut1.pc, 6);

    // asynchronous reset mid-run, before any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    cmp_dut1("async_rst");
    check("async_rst_div", int'(dut2.div_cnt), 0);

    // saturating switch value and random ones
    run_default(15, 12);
    for (int k = 0; k < 4; k++) begin
      s = int'($urandom_range(0, 15));
      run_default(s, 50);
    end

    // prescaler of 4
    rst_n = 1'b0;
    sw = 4'h6;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check("div4_pc", dut2.pc, k / 4);
      check("div4_led", led2, (k >= 12) ? 6 : 0);
    end

    // custom ROM with random switches every step
    rst_n = 1'b0;
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    pa = 0; pb = 0; pl = 0;
    for (int i = 1; i <= 120; i++) begin
      s = int'($urandom_range(0, 15));
      sw = 4'(s);
      @(negedge clk);
      model_step(1, s);
      check("cov.led",   led3,       m_led);
      check("cov.pc",    dut3.pc,    m_pc);
      check("cov.a",     dut3.a,     m_a);
      check("cov.b",     dut3.b,     m_b);
      check("cov.carry", dut3.carry, m_c);
      if (i == 2) begin
        check("addc_a", dut3.a, 1);
        check("addc_carry", dut3.carry, 1);
      end
      if (i == 3) check("jnc_not_taken", dut3.pc, 3);
      if (i == 4) check("movab_carry", dut3.carry, 0);
      if (i == 5) begin
        check("jnc_taken", dut3.pc, 6);
        pa = dut3.a; pb = dut3.b; pl = led3;
      end
      if (i == 6) begin
        check("nop_pc", dut3.pc, 7);
        check("nop_a", dut3.a, pa);
        check("nop_b", dut3.b, pb);
        check("nop_led", led3, pl);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
